// File: rtl/fpu_op_sequencer.sv
// fpu_op_sequencer: request sequencer in front of an FPU (fpnew_top style).
// Accepts (a, b, op, rnd) requests into a FIFO, issues them to the FPU with a
// rotating tag, collects out-of-order completions into a reorder buffer and
// retires responses strictly in acceptance order.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   serial_mode_i                1: issue only when nothing is in flight
//   req_*                        requester side (valid/ready, operands, op, rnd)
//   fpu_*_o / fpu_*_i            FPU issue and result interfaces, flush
//   rsp_*                        in-order responses (valid/ready, result, status, seq)
//   outstanding_o                number of ops between issue and retire
//   err_o                        sticky: result returned with a tag not in flight
module fpu_op_sequencer #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned MAX_OUT = 4,
  parameter int unsigned OP_W    = 4,
  parameter int unsigned SEQ_W   = 8,
  localparam int unsigned TAG_W  = $clog2(MAX_OUT)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               serial_mode_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [WIDTH-1:0]   req_a_i,
  input  logic [WIDTH-1:0]   req_b_i,
  input  logic [OP_W-1:0]    req_op_i,
  input  logic [2:0]         req_rnd_i,
  output logic [3*WIDTH-1:0] fpu_operands_o,
  output logic [OP_W-1:0]    fpu_op_o,
  output logic [2:0]         fpu_rnd_o,
  output logic [TAG_W-1:0]   fpu_tag_o,
  output logic               fpu_in_valid_o,
  input  logic               fpu_in_ready_i,
  input  logic [WIDTH-1:0]   fpu_result_i,
  input  logic [4:0]         fpu_status_i,
  input  logic [TAG_W-1:0]   fpu_tag_i,
  input  logic               fpu_out_valid_i,
  output logic               fpu_out_ready_o,
  output logic               fpu_flush_o,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [WIDTH-1:0]   rsp_result_o,
  output logic [4:0]         rsp_status_o,
  output logic [SEQ_W-1:0]   rsp_seq_o,
  output logic [TAG_W:0]     outstanding_o,
  output logic               err_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [OP_W-1:0] OpAdd = OP_W'(2);
  localparam logic [OP_W-1:0] OpSqrt = OP_W'(5);
  localparam logic [TAG_W:0] MaxOut = (TAG_W + 1)'(MAX_OUT);

  typedef enum logic [1:0] {SlotFree, SlotBusy, SlotDone} slot_e;

  // Request FIFO
  logic [WIDTH-1:0] r_fifo_a   [DEPTH];
  logic [WIDTH-1:0] r_fifo_b   [DEPTH];
  logic [OP_W-1:0]  r_fifo_op  [DEPTH];
  logic [2:0]       r_fifo_rnd [DEPTH];
  logic [PTR_W:0]   r_wr_ptr, r_rd_ptr;

  // Reorder buffer, indexed by tag
  slot_e            r_slot     [MAX_OUT];
  logic [WIDTH-1:0] r_rob_res  [MAX_OUT];
  logic [4:0]       r_rob_stat [MAX_OUT];

  logic [TAG_W-1:0] r_issue_tag, r_retire_tag;
  logic [SEQ_W-1:0] r_retire_seq;
  logic [TAG_W:0]   r_outstanding;
  logic             r_flush, r_hold, r_err;

  logic               w_empty, w_full, w_push, w_issue_cond, w_in_valid, w_issue;
  logic               w_complete, w_bad_tag, w_rsp_valid, w_retire;
  logic [PTR_W-1:0]   w_head, w_tail;
  logic [WIDTH-1:0]   w_a, w_b;
  logic [OP_W-1:0]    w_op;
  logic [3*WIDTH-1:0] w_operands;

  assign w_head  = r_rd_ptr[PTR_W-1:0];
  assign w_tail  = r_wr_ptr[PTR_W-1:0];
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) && (w_head == w_tail);

  // Held low during the flush cycle so nothing is accepted before the FPU is clean.
  assign req_ready_o = !w_full && !r_flush;
  assign w_push      = req_valid_i && req_ready_o;

  assign w_issue_cond = !w_empty && (r_outstanding < MaxOut) &&
                        (r_slot[r_issue_tag] == SlotFree) &&
                        (!serial_mode_i || (r_outstanding == '0)) && !r_flush;
  // r_hold keeps valid up if serial mode is switched on while waiting for ready.
  assign w_in_valid   = w_issue_cond || r_hold;
  assign w_issue      = w_in_valid && fpu_in_ready_i;

  assign w_complete = fpu_out_valid_i && !r_flush && (r_slot[fpu_tag_i] == SlotBusy);
  assign w_bad_tag  = fpu_out_valid_i && !r_flush && (r_slot[fpu_tag_i] != SlotBusy);

  assign w_rsp_valid = (r_slot[r_retire_tag] == SlotDone);
  assign w_retire    = w_rsp_valid && rsp_ready_i;

  assign w_a  = r_fifo_a[w_head];
  assign w_b  = r_fifo_b[w_head];
  assign w_op = r_fifo_op[w_head];

  // Operand routing: ADD uses slots 1/2, SQRT slot 0 only, others slots 0/1.
  always_comb begin
    w_operands = '0;
    if (w_in_valid) begin
      case (w_op)
        OpAdd:   w_operands = {w_b, w_a, {WIDTH{1'b0}}};
        OpSqrt:  w_operands = {{WIDTH{1'b0}}, {WIDTH{1'b0}}, w_a};
        default: w_operands = {{WIDTH{1'b0}}, w_b, w_a};
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_flush       <= 1'b1;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_issue_tag   <= '0;
      r_retire_tag  <= '0;
      r_retire_seq  <= '0;
      r_outstanding <= '0;
      r_hold        <= 1'b0;
      r_err         <= 1'b0;
      r_slot        <= '{default: SlotFree};
    end else begin
      r_flush <= 1'b0;
      r_hold  <= w_in_valid && !fpu_in_ready_i;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_issue) begin
        r_rd_ptr            <= r_rd_ptr + 1'b1;
        r_issue_tag         <= r_issue_tag + 1'b1;
        r_slot[r_issue_tag] <= SlotBusy;
      end
      if (w_complete) r_slot[fpu_tag_i] <= SlotDone;
      if (w_bad_tag) r_err <= 1'b1;
      if (w_retire) begin
        r_slot[r_retire_tag] <= SlotFree;
        r_retire_tag         <= r_retire_tag + 1'b1;
        r_retire_seq         <= r_retire_seq + 1'b1;
      end
      case ({w_issue, w_retire})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  // Data storage needs no reset; validity is tracked by pointers and slot state.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo_a[w_tail]   <= req_a_i;
      r_fifo_b[w_tail]   <= req_b_i;
      r_fifo_op[w_tail]  <= req_op_i;
      r_fifo_rnd[w_tail] <= req_rnd_i;
    end
    if (w_complete) begin
      r_rob_res[fpu_tag_i]  <= fpu_result_i;
      r_rob_stat[fpu_tag_i] <= fpu_status_i;
    end
  end

  assign fpu_operands_o  = w_operands;
  assign fpu_op_o        = w_in_valid ? w_op : '0;
  assign fpu_rnd_o       = w_in_valid ? r_fifo_rnd[w_head] : '0;
  assign fpu_tag_o       = r_issue_tag;
  assign fpu_in_valid_o  = w_in_valid;
  assign fpu_out_ready_o = !rst_i;
  assign fpu_flush_o     = r_flush;
  assign rsp_valid_o     = w_rsp_valid;
  assign rsp_result_o    = w_rsp_valid ? r_rob_res[r_retire_tag] : '0;
  assign rsp_status_o    = w_rsp_valid ? r_rob_stat[r_retire_tag] : '0;
  assign rsp_seq_o       = r_retire_seq;
  assign outstanding_o   = r_outstanding;
  assign err_o           = r_err;

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Directed self-checking bench for fpu_op_sequencer. The bench plays the FPU:
// it keeps fpu_in_ready_i high and returns results by tag under test control.
module tb_fpu_op_sequencer;

  localparam logic [3:0] OpAdd = 4'd2, OpMul = 4'd3, OpDiv = 4'd4, OpSqrt = 4'd5;

  logic        clk, rst, serial_mode, req_valid, req_ready;
  logic [31:0] req_a, req_b;
  logic [3:0]  req_op;
  logic [2:0]  req_rnd;
  logic [95:0] fpu_operands;
  logic [3:0]  fpu_op;
  logic [2:0]  fpu_rnd;
  logic [1:0]  fpu_tag_o, fpu_tag_i;
  logic        fpu_in_valid, fpu_in_ready, fpu_out_valid, fpu_out_ready, fpu_flush;
  logic [31:0] fpu_result;
  logic [4:0]  fpu_status;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_result;
  logic [4:0]  rsp_status;
  logic [7:0]  rsp_seq;
  logic [2:0]  outstanding;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [1:0]  iss_tag_q[$];
  logic [95:0] iss_ops_q[$];
  logic [7:0]  rsp_seq_q[$];
  logic [31:0] rsp_res_q[$];
  int          peak_out;
  int          serial_viol;

  fpu_op_sequencer dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .serial_mode_i  (serial_mode),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_a_i        (req_a),
    .req_b_i        (req_b),
    .req_op_i       (req_op),
    .req_rnd_i      (req_rnd),
    .fpu_operands_o (fpu_operands),
    .fpu_op_o       (fpu_op),
    .fpu_rnd_o      (fpu_rnd),
    .fpu_tag_o      (fpu_tag_o),
    .fpu_in_valid_o (fpu_in_valid),
    .fpu_in_ready_i (fpu_in_ready),
    .fpu_result_i   (fpu_result),
    .fpu_status_i   (fpu_status),
    .fpu_tag_i      (fpu_tag_i),
    .fpu_out_valid_i(fpu_out_valid),
    .fpu_out_ready_o(fpu_out_ready),
    .fpu_flush_o    (fpu_flush),
    .rsp_valid_o    (rsp_valid),
    .rsp_ready_i    (rsp_ready),
    .rsp_result_o   (rsp_result),
    .rsp_status_o   (rsp_status),
    .rsp_seq_o      (rsp_seq),
    .outstanding_o  (outstanding),
    .err_o          (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitors sample on the falling edge; inputs only change 1ns after a rising edge.
  always @(negedge clk) begin
    if (rst) begin
      iss_tag_q.delete();
      iss_ops_q.delete();
      rsp_seq_q.delete();
      rsp_res_q.delete();
      peak_out    = 0;
      serial_viol = 0;
    end else begin
      if (fpu_in_valid && fpu_in_ready) begin
        iss_tag_q.push_back(fpu_tag_o);
        iss_ops_q.push_back(fpu_operands);
      end
      if (rsp_valid && rsp_ready) begin
        rsp_seq_q.push_back(rsp_seq);
        rsp_res_q.push_back(rsp_result);
      end
      if (int'(outstanding) > peak_out) peak_out = int'(outstanding);
      if (serial_mode && fpu_in_valid && outstanding != 3'd0) serial_viol++;
    end
  end

  task automatic idle_inputs();
    serial_mode   = 1'b0;
    req_valid     = 1'b0;
    req_a         = '0;
    req_b         = '0;
    req_op        = '0;
    req_rnd       = '0;
    fpu_in_ready  = 1'b1;
    fpu_out_valid = 1'b0;
    fpu_tag_i     = '0;
    fpu_result    = '0;
    fpu_status    = '0;
    rsp_ready     = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    int n = 0;
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    req_op    = op;
    req_rnd   = 3'd1;
    while (!req_ready && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL push_timeout got req_ready=0 want 1");
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic send_result(input logic [1:0] tag, input logic [31:0] res, input logic [4:0] st);
    fpu_out_valid = 1'b1;
    fpu_tag_i     = tag;
    fpu_result    = res;
    fpu_status    = st;
    @(posedge clk);
    #1 fpu_out_valid = 1'b0;
  endtask

  task automatic wait_iss(input int n);
    int c = 0;
    while (iss_tag_q.size() < n && c < 100) begin
      @(posedge clk);
      #1 c++;
    end
    checks++;
    if (iss_tag_q.size() < n) begin
      errors++;
      $display("FAIL wait_iss got %0d issues want %0d", iss_tag_q.size(), n);
    end
  endtask

  task automatic wait_rsp(input int n);
    int c = 0;
    while (rsp_seq_q.size() < n && c < 100) begin
      @(posedge clk);
      #1 c++;
    end
    checks++;
    if (rsp_seq_q.size() < n) begin
      errors++;
      $display("FAIL wait_rsp got %0d responses want %0d", rsp_seq_q.size(), n);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks += 7;
    if (fpu_flush !== 1'b1) begin errors++; $display("FAIL rst_flush got %b want 1", fpu_flush); end
    if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready got %b want 0", req_ready); end
    if (fpu_in_valid !== 1'b0) begin errors++; $display("FAIL rst_in_valid got %b want 0", fpu_in_valid); end
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %b want 0", rsp_valid); end
    if (outstanding !== 3'd0) begin errors++; $display("FAIL rst_outst got %0d want 0", outstanding); end
    if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", err); end
    if (fpu_out_ready !== 1'b0) begin errors++; $display("FAIL rst_out_ready got %b want 0", fpu_out_ready); end
    rst = 1'b0;
    #1;
    checks++;
    if (fpu_flush !== 1'b1) begin errors++; $display("FAIL flush_hold got %b want 1", fpu_flush); end
    @(posedge clk);
    #1;
    checks += 3;
    if (fpu_flush !== 1'b0) begin errors++; $display("FAIL flush_clear got %b want 0", fpu_flush); end
    if (req_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready got %b want 1", req_ready); end
    if (fpu_out_ready !== 1'b1) begin errors++; $display("FAIL post_rst_out_ready got %b want 1", fpu_out_ready); end
  endtask

  task automatic test_add();
    do_reset();
    push(32'h40A147AE, 32'h41800000, OpAdd);
    checks += 4;
    if (fpu_in_valid !== 1'b1) begin errors++; $display("FAIL add_valid got %b want 1", fpu_in_valid); end
    if (fpu_operands !== {32'h41800000, 32'h40A147AE, 32'h0}) begin
      errors++; $display("FAIL add_operands got %h want %h", fpu_operands, {32'h41800000, 32'h40A147AE, 32'h0});
    end
    if (fpu_op !== OpAdd) begin errors++; $display("FAIL add_op got %0d want 2", fpu_op); end
    if (fpu_tag_o !== 2'd0) begin errors++; $display("FAIL add_tag got %0d want 0", fpu_tag_o); end
    @(posedge clk);
    #1;
    checks++;
    if (outstanding !== 3'd1) begin errors++; $display("FAIL add_outst got %0d want 1", outstanding); end
    send_result(2'd0, 32'h41A851EC, 5'h01);
    checks += 4;
    if (rsp_valid !== 1'b1) begin errors++; $display("FAIL add_rsp_valid got %b want 1", rsp_valid); end
    if (rsp_seq !== 8'd0) begin errors++; $display("FAIL add_seq got %0d want 0", rsp_seq); end
    if (rsp_result !== 32'h41A851EC) begin errors++; $display("FAIL add_result got %h want 41a851ec", rsp_result); end
    if (rsp_status !== 5'h01) begin errors++; $display("FAIL add_status got %h want 01", rsp_status); end
    @(posedge clk);
    #1;
    checks += 2;
    if (outstanding !== 3'd0) begin errors++; $display("FAIL add_outst_end got %0d want 0", outstanding); end
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL add_rsp_end got %b want 0", rsp_valid); end
  endtask

  task automatic test_routing();
    do_reset();
    push(32'h43700000, 32'h12345678, OpSqrt);
    checks += 2;
    if (fpu_operands !== {32'h0, 32'h0, 32'h43700000}) begin
      errors++; $display("FAIL sqrt_operands got %h want %h", fpu_operands, {32'h0, 32'h0, 32'h43700000});
    end
    if (fpu_op !== OpSqrt) begin errors++; $display("FAIL sqrt_op got %0d want 5", fpu_op); end
    @(posedge clk);
    #1;
    push(32'h41400000, 32'h3F800000, OpMul);
    checks += 2;
    if (fpu_operands !== {32'h0, 32'h3F800000, 32'h41400000}) begin
      errors++; $display("FAIL mul_operands got %h want %h", fpu_operands, {32'h0, 32'h3F800000, 32'h41400000});
    end
    if (fpu_tag_o !== 2'd1) begin errors++; $display("FAIL mul_tag got %0d want 1", fpu_tag_o); end
    @(posedge clk);
    #1;
    send_result(2'd0, 32'h41800000, 5'h0);
    send_result(2'd1, 32'h41400000, 5'h0);
    wait_rsp(2);
    checks += 2;
    if (rsp_seq_q[1] !== 8'd1) begin errors++; $display("FAIL route_seq got %0d want 1", rsp_seq_q[1]); end
    if (rsp_res_q[1] !== 32'h41400000) begin errors++; $display("FAIL route_res got %h want 41400000", rsp_res_q[1]); end
  endtask

  task automatic test_pipelined();
    logic [31:0] exp_res[5] = '{32'hC0DE0000, 32'hC0DE0001, 32'hC0DE0002, 32'hC0DE0003, 32'hC0DE0010};
    do_reset();
    for (int k = 0; k < 5; k++) push(32'h40000000 + k, 32'h3F800000, OpMul);
    @(posedge clk);
    #1;
    checks += 3;
    if (outstanding !== 3'd4) begin errors++; $display("FAIL pipe_outst got %0d want 4", outstanding); end
    if (fpu_in_valid !== 1'b0) begin errors++; $display("FAIL pipe_5th_blocked got %b want 0", fpu_in_valid); end
    if (iss_tag_q.size() != 4) begin errors++; $display("FAIL pipe_issued got %0d want 4", iss_tag_q.size()); end
    send_result(2'd3, exp_res[3], 5'h0);
    send_result(2'd1, exp_res[1], 5'h0);
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL pipe_no_early_rsp got %b want 0", rsp_valid); end
    send_result(2'd0, exp_res[0], 5'h0);
    checks += 2;
    if (rsp_valid !== 1'b1) begin errors++; $display("FAIL pipe_rsp0 got %b want 1", rsp_valid); end
    if (fpu_in_valid !== 1'b0) begin errors++; $display("FAIL pipe_wait_retire got %b want 0", fpu_in_valid); end
    @(posedge clk);
    #1;
    checks++;
    if (fpu_in_valid !== 1'b1) begin errors++; $display("FAIL pipe_5th_after_retire got %b want 1", fpu_in_valid); end
    send_result(2'd2, exp_res[2], 5'h0);
    wait_iss(5);
    checks++;
    if (iss_tag_q[4] !== 2'd0) begin errors++; $display("FAIL pipe_tag_wrap got %0d want 0", iss_tag_q[4]); end
    send_result(2'd0, exp_res[4], 5'h0);
    wait_rsp(5);
    for (int k = 0; k < 5; k++) begin
      checks += 2;
      if (rsp_seq_q[k] !== 8'(k)) begin errors++; $display("FAIL pipe_seq%0d got %0d want %0d", k, rsp_seq_q[k], k); end
      if (rsp_res_q[k] !== exp_res[k]) begin
        errors++; $display("FAIL pipe_res%0d got %h want %h", k, rsp_res_q[k], exp_res[k]);
      end
    end
    checks++;
    if (peak_out != 4) begin errors++; $display("FAIL pipe_peak got %0d want 4", peak_out); end
  endtask

  task automatic test_serial();
    do_reset();
    serial_mode = 1'b1;
    for (int k = 0; k < 3; k++) push(32'h41000000 + k, 32'h40000000, OpDiv);
    for (int k = 0; k < 3; k++) begin
      wait_iss(k + 1);
      repeat (3) @(posedge clk);
      #1;
      checks += 2;
      if (outstanding !== 3'd1) begin errors++; $display("FAIL serial_outst%0d got %0d want 1", k, outstanding); end
      if (fpu_in_valid !== 1'b0) begin errors++; $display("FAIL serial_blocked%0d got %b want 0", k, fpu_in_valid); end
      send_result(2'(k), 32'h3F000000 + k, 5'h0);
    end
    wait_rsp(3);
    checks += 2;
    if (rsp_seq_q[2] !== 8'd2) begin errors++; $display("FAIL serial_seq got %0d want 2", rsp_seq_q[2]); end
    if (serial_viol != 0) begin errors++; $display("FAIL serial_overlap got %0d want 0", serial_viol); end
  endtask

  task automatic test_backpressure();
    logic [1:0] ret_order[4] = '{2'd2, 2'd0, 2'd3, 2'd1};
    do_reset();
    rsp_ready = 1'b0;
    for (int k = 0; k < 8; k++) push(32'h3F800000 + k, 32'h40000000, OpMul);
    checks += 3;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_req_ready got %b want 0", req_ready); end
    if (fpu_in_valid !== 1'b0) begin errors++; $display("FAIL bp_in_valid got %b want 0", fpu_in_valid); end
    if (outstanding !== 3'd4) begin errors++; $display("FAIL bp_outst got %0d want 4", outstanding); end
    for (int k = 0; k < 4; k++) send_result(ret_order[k], 32'hA0000000 + ret_order[k], 5'h0);
    @(posedge clk);
    #1;
    checks += 3;
    if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_rsp_held got %b want 1", rsp_valid); end
    if (fpu_in_valid !== 1'b0) begin errors++; $display("FAIL bp_rob_full got %b want 0", fpu_in_valid); end
    if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_fifo_full got %b want 0", req_ready); end
    rsp_ready = 1'b1;
    for (int k = 4; k < 8; k++) begin
      wait_iss(k + 1);
      send_result(iss_tag_q[k], 32'hA0000000 + k, 5'h0);
    end
    wait_rsp(8);
    for (int k = 0; k < 8; k++) begin
      checks += 3;
      if (rsp_seq_q[k] !== 8'(k)) begin errors++; $display("FAIL bp_seq%0d got %0d want %0d", k, rsp_seq_q[k], k); end
      if (rsp_res_q[k] !== 32'hA0000000 + k) begin
        errors++; $display("FAIL bp_res%0d got %h want %h", k, rsp_res_q[k], 32'hA0000000 + k);
      end
      if (iss_ops_q[k][31:0] !== 32'h3F800000 + k) begin
        errors++; $display("FAIL bp_opa%0d got %h want %h", k, iss_ops_q[k][31:0], 32'h3F800000 + k);
      end
    end
  endtask

  task automatic test_err();
    do_reset();
    send_result(2'd2, 32'hDEADBEEF, 5'h0);
    checks += 2;
    if (err !== 1'b1) begin errors++; $display("FAIL err_set got %b want 1", err); end
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL err_no_rsp got %b want 0", rsp_valid); end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", err); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    push(32'h40A147AE, 32'h41800000, OpAdd);
    push(32'h41400000, 32'h3F800000, OpMul);
    wait_iss(2);
    send_result(2'd1, 32'h11111111, 5'h0);
    rst           = 1'b1;
    fpu_out_valid = 1'b1;
    fpu_tag_i     = 2'd0;
    #1;
    checks += 4;
    if (fpu_flush !== 1'b1) begin errors++; $display("FAIL mid_flush got %b want 1", fpu_flush); end
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_rsp got %b want 0", rsp_valid); end
    if (outstanding !== 3'd0) begin errors++; $display("FAIL mid_outst got %0d want 0", outstanding); end
    if (fpu_in_valid !== 1'b0) begin errors++; $display("FAIL mid_in_valid got %b want 0", fpu_in_valid); end
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 fpu_out_valid = 1'b0;
    checks += 3;
    if (err !== 1'b0) begin errors++; $display("FAIL mid_flush_drop got err=%b want 0", err); end
    if (fpu_flush !== 1'b0) begin errors++; $display("FAIL mid_flush_end got %b want 0", fpu_flush); end
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_rsp_after got %b want 0", rsp_valid); end
    push(32'h40000000, 32'h40400000, OpAdd);
    @(posedge clk);
    #1;
    send_result(2'd0, 32'h40A00000, 5'h0);
    checks += 2;
    if (rsp_seq !== 8'd0) begin errors++; $display("FAIL mid_seq got %0d want 0", rsp_seq); end
    if (rsp_result !== 32'h40A00000) begin errors++; $display("FAIL mid_res got %h want 40a00000", rsp_result); end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_add();
    test_routing();
    test_pipelined();
    test_serial();
    test_backpressure();
    test_err();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_op_sequencer.md
Name: fpu_op_sequencer

Overview:
- Synthesizable request sequencer sitting between a requester and the fpnew_top FPU instance (DEFAULT_HUB implementation).
- Successor to the single-op, blocking send/wait driver flow. Adds a parametrised request FIFO, multiple outstanding ops tracked by tag, an in-order reorder buffer for out-of-order FPU completion, and a selectable serial or pipelined issue mode.
- Performs op-aware operand routing, so requesters always supply (a, b).

Parameters:
- WIDTH, 32, FP operand/result width.
- DEPTH, 4, request FIFO entries (power of 2, ≥2).
- MAX_OUT, 4, max in-flight FPU ops; also ROB entries (power of 2, ≥2).
- OP_W, 4, op code width; encoding per fpnew_pkg::operation_e (ADD=2, MUL=3, DIV=4, SQRT=5).
- SEQ_W, 8, response sequence number width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- serial_mode_i  in  1  1: issue only when nothing is outstanding; 0: pipelined.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request FIFO not full.
- req_a_i  in  WIDTH  first operand.
- req_b_i  in  WIDTH  second operand.
- req_op_i  in  OP_W  operation.
- req_rnd_i  in  3  rounding mode.
- fpu_operands_o  out  3*WIDTH  routed operands [2:0].
- fpu_op_o  out  OP_W  op to FPU.
- fpu_rnd_o  out  3  rounding mode to FPU.
- fpu_tag_o  out  log2(MAX_OUT)  issue tag.
- fpu_in_valid_o  out  1  FPU input valid.
- fpu_in_ready_i  in  1  FPU input ready.
- fpu_result_i  in  WIDTH  FPU result.
- fpu_status_i  in  5  FPU status flags.
- fpu_tag_i  in  log2(MAX_OUT)  returned tag.
- fpu_out_valid_i  in  1  FPU result valid.
- fpu_out_ready_o  out  1  always 1 outside reset.
- fpu_flush_o  out  1  FPU flush.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response ready.
- rsp_result_o  out  WIDTH  result.
- rsp_status_o  out  5  status.
- rsp_seq_o  out  SEQ_W  request sequence number, in acceptance order.
- outstanding_o  out  log2(MAX_OUT)+1  in-flight count.
- err_o  out  1  sticky: result arrived with a tag that is not outstanding.

Behaviour:
- Reset values:
  - All outputs 0, except fpu_flush_o=1.
  - FIFO and ROB empty; all counters 0; all ROB entries invalid.
  - fpu_flush_o deasserts at the first clk_i edge after rst_i falls.
  - Reset mid-operation discards all queued and in-flight ops. Results arriving while fpu_flush_o=1 are dropped and do not set err_o.
- Request accept: push on req_valid_i & req_ready_o. req_ready_o = !fifo_full and does not depend on same-cycle pop.
- Issue condition: fifo non-empty & outstanding_o<MAX_OUT & ROB slot[issue_tag] free & (!serial_mode_i | outstanding_o==0) & !fpu_flush_o.
  - fpu_in_valid_o is driven combinationally from that condition.
  - Once asserted, fpu_in_valid_o and all FPU payload stay stable until fpu_in_ready_i. The FIFO head does not change while valid and not ready.
- Handshake: on fpu_in_valid_o & fpu_in_ready_i, pop the FIFO and mark ROB[issue_tag] busy. issue_tag and issue_seq increment; tag wraps mod MAX_OUT, seq wraps mod 2^SEQ_W.
- Operand routing (slot0, slot1, slot2):
  - ADD: (0, a, b).
  - SQRT: (a, 0, 0).
  - All other ops: (a, b, 0).
- Completion: on fpu_out_valid_i, if ROB[fpu_tag_i] is busy, store result and status and mark it done. Otherwise set err_o and drop the result.
- Retire: rsp_valid_o=1 when ROB[retire_tag] is done.
  - rsp_* outputs are driven from that entry; rsp_seq_o = retire_seq.
  - On rsp_ready_i the entry is freed and retire_tag/retire_seq increment.
  - Responses are always in acceptance order, regardless of FPU completion order.
- outstanding_o counts entries from issue until retire. Issue and retire in the same cycle leave it unchanged.
- Completion and retire on the same slot in the same cycle cannot occur, because a slot is retired only when done.
- Serial mode toggled mid-stream takes effect on the next issue decision. In-flight ops are unaffected.

Test Plan:
- Reset then one ADD with a=0x40A147AE, b=0x41800000 -> fpu_operands_o={0x41800000, 0x40A147AE, 0}; one response with rsp_seq_o=0 and rsp_result_o equal to the FPU result; outstanding_o returns to 0.
- SQRT with a=0x43700000 -> fpu_operands_o={0, 0, 0x43700000}. MUL with 0x41400000, 0x3F800000 -> {0, 0x3F800000, 0x41400000}.
- Pipelined mode: 4 MULs back-to-back, model returns tags 3, 1, 0, 2 -> responses carry seq 0, 1, 2, 3 in order; outstanding_o peaks at 4; 5th request waits to issue until the first retire.
- Serial mode: 3 DIVs -> fpu_in_valid_o never asserts while outstanding_o=1.
- Backpressure: rsp_ready_i=0 with a full FIFO and full ROB -> req_ready_o=0, fpu_in_valid_o=0, no data lost; after release, 8 responses with seq 0..7.
- Result with a non-outstanding tag -> err_o=1 and stays 1. rst_i mid-stream -> fpu_flush_o=1, rsp_valid_o=0, counters 0; post-reset ops start at seq 0.
